// File: rtl/iiitb_ptvm_pkg.sv
// Shared coin codes and detector state encoding for the coin acceptor and vending machine.
package iiitb_ptvm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        WAIT_REL
    } det_state_t;

    function automatic logic is_coin(input logic [1:0] code);
        return (code == COIN_5) || (code == COIN_10);
    endfunction

endpackage

// File: rtl/iiitb_ptvm_coin_fifo.sv
// Small synchronous FIFO buffering qualified coin codes until the vending FSM takes them.
module iiitb_ptvm_coin_fifo
    import iiitb_ptvm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [1:0]                    push_code,
    input  logic                          pop,
    output logic [1:0]                    head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_code;
    end

endmodule

// File: rtl/iiitb_ptvm_coin_acceptor.sv
// Coin acceptor: synchronises and debounces the two coin sensors, buffers coins and
// issues them one per pulse to the vending FSM.
module iiitb_ptvm_coin_acceptor
    import iiitb_ptvm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sense5,
    input  logic                          sense10,
    input  logic                          hold,
    output logic [1:0]                    in,
    output logic                          reject,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    logic [1:0]  sync_a;
    logic [1:0]  s;
    det_state_t  state;
    logic [1:0]  pattern;
    logic [3:0]  qcnt;
    logic        qualified;
    logic        coin_push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [1:0]  head;

    // Reset to "coin present" so a coin held through reset must be released first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 2'b11;
            s      <= 2'b11;
        end else begin
            sync_a <= {sense10, sense5};
            s      <= sync_a;
        end
    end

    assign qualified = (state == QUAL) && (s == pattern) &&
                       (qcnt == 4'(DEBOUNCE_CYCLES - 1));
    assign coin_push = qualified && is_coin(pattern);
    assign pop       = !empty && !hold && (in == COIN_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_REL;
            pattern <= COIN_NONE;
            qcnt    <= '0;
            reject  <= 1'b0;
        end else begin
            reject <= (qualified && (pattern == COIN_RSVD)) ||
                      (coin_push && full && !pop);
            case (state)
                IDLE: begin
                    if (s != COIN_NONE) begin
                        state   <= QUAL;
                        pattern <= s;
                        qcnt    <= 4'd1;
                    end
                end
                QUAL: begin
                    if (s != pattern) begin
                        state <= IDLE;
                        qcnt  <= '0;
                    end else if (qualified) begin
                        state <= WAIT_REL;
                        qcnt  <= '0;
                    end else begin
                        qcnt <= qcnt + 4'd1;
                    end
                end
                WAIT_REL: begin
                    if (s == COIN_NONE) state <= IDLE;
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

    // Registered issue stage: a coin shows for one cycle and is followed by a 00 gap.
    always_ff @(posedge clk) begin
        if (rst)
            in <= COIN_NONE;
        else
            in <= pop ? head : COIN_NONE;
    end

    iiitb_ptvm_coin_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (coin_push),
        .push_code (pattern),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: doc/iiitb_ptvm_coin_acceptor.md
IIITB_PTVM_COIN_ACCEPTOR -- requirements
Module: iiitb_ptvm_coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronised samples required to qualify a coin (range 2..15).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning coin buffer entries (power of two, at least 2).
REQ-003 Port clk  input  1  single clock; all state SHALL be on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port sense5  input  1  raw 5-unit coin sensor, asynchronous, high while a coin is in the chute.
REQ-006 Port sense10  input  1  raw 10-unit coin sensor, asynchronous, high while a coin is in the chute.
REQ-007 Port hold  input  1  vending FSM busy; while high, no coin is issued.
REQ-008 Port in  output  2  coin code to vending FSM: 00 none, 01 five, 10 ten; 11 is never driven.
REQ-009 Port reject  output  1  one-cycle pulse meaning the coin was diverted to the return chute.
REQ-010 Port count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-011 sense5/sense10 SHALL each pass a 2-flop synchroniser; s denotes the synchronised pair {sense10,sense5}.
REQ-012 Detector FSM SHALL have states IDLE, QUAL, WAIT_REL.
REQ-013 IDLE: s!=00 -> QUAL, capture s as pattern, qualification counter=1.
REQ-014 QUAL: s==pattern -> counter+1; s!=pattern (drop or change) -> IDLE, no event, no reject (glitch).
REQ-015 QUAL: on the edge where counter reaches DEBOUNCE_CYCLES, one event SHALL fire and the FSM SHALL go to WAIT_REL.
REQ-016 Event with pattern 01 -> push 01; pattern 10 -> push 10; pattern 11 -> no push, reject pulse.
REQ-017 Push when FIFO full and no pop that cycle -> coin dropped, reject pulse; full with a simultaneous pop -> push accepted.
REQ-018 WAIT_REL: s==00 for one sample -> IDLE; one held coin SHALL yield at most one event.
REQ-019 Issue stage: in is registered, default 00.
REQ-020 When FIFO non-empty, hold low, and in was 00 in the previous cycle, in SHALL present the head code for exactly one cycle and the head is popped that cycle.
REQ-021 At least one in=00 gap cycle SHALL separate consecutive coins.
REQ-022 hold rising during an issue cycle SHALL NOT truncate that cycle; no new issue SHALL start while hold is high.
REQ-023 Raw-rise-to-in latency with an empty FIFO and hold low SHALL be 2+DEBOUNCE_CYCLES+1 cycles.
REQ-024 Coins SHALL issue in insertion order; count SHALL update the cycle after each push or pop, unchanged on simultaneous push and pop.

Reset
REQ-025 rst SHALL produce in=00, reject=0, count=0, FIFO flushed, counter=0, FSM=WAIT_REL.
REQ-026 Synchroniser flops SHALL reset to 1 so a coin held across reset is not counted; the FSM leaves WAIT_REL only after a genuine release.
REQ-027 rst mid-qualification or mid-issue SHALL abort with no event, no reject, and no partial in pulse.

Structure
REQ-028 Package iiitb_ptvm_pkg SHALL hold the coin code constants (COIN_NONE, COIN_5, COIN_10, COIN_RSVD) and the detector state enum, shared with iiitb_ptv_machine.
REQ-029 The buffer SHALL be sub-module iiitb_ptvm_coin_fifo (synchronous FIFO, push/pop/full/empty/count); the detector and issue logic stay in the top.

Verification
REQ-030 Test 1: sense5 high 8 cycles, DEBOUNCE_CYCLES=4 -> exactly one in=01 pulse, 7 cycles after rise; reject never asserts.
REQ-031 Test 2: sense10 high 3 cycles, then low -> no coin, no reject; then a 6-cycle sense10 pulse -> one in=10.
REQ-032 Test 3: sense5 and sense10 high together 6 cycles -> one reject pulse; in stays 00.
REQ-033 Test 4: hold=1, insert 5 coins (01,10,01,10,01), FIFO_DEPTH=4 -> count=4, 5th coin rejected; release hold -> in=01,00,10,00,01,00,10.
REQ-034 Test 5: rst asserted while sense5 held and 2 coins queued -> in=00, count=0; no coin issued until sense5 releases and a new coin is inserted.
REQ-035 Test 6: back-to-back coins with hold low -> every in pulse is one cycle wide with at least one 00 cycle between pulses; in is never 11.
